// File: rtl/tama_pkg.sv
// tama_pkg: command codes and receiver state encoding shared by the UART front end and the stats stage.
package tama_pkg;
    localparam logic [7:0] CMD_NONE  = 8'h00;
    localparam logic [7:0] CMD_EAT   = 8'h65;
    localparam logic [7:0] CMD_SLEEP = 8'h73;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, m} <= {2{RST_VAL}};
        else {q, m} <= {m, d};
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 receiver that holds each received byte on cmd for a fixed window,
// always separating consecutive commands with at least one 0x00 cycle.
module uart_cmd_rx
    import tama_pkg::*;
#(
    parameter int CLK_HZ      = 27000000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW = $clog2(CPB + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2);
    localparam logic [CW-1:0] FULL = CW'(CPB);
    localparam logic [HW-1:0] HOLD = HW'(HOLD_CYCLES);

    logic rxs, done, accept, bad, pend;
    rx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sr, sr_n;
    logic [HW-1:0] hold;

    sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rxs));

    // cnt counts down to 1; the cycle it reads 1 is the sampling point
    assign done   = cnt == CW'(1);
    assign accept = state == STOP && done && rxs;
    assign bad    = state == STOP && done && !rxs;
    assign busy   = state != IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sr    <= sr_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
        idx_n   = idx;
        sr_n    = sr;
        case (state)
            IDLE: if (!rxs) begin
                state_n = START;
                cnt_n   = HALF;
            end
            START: if (done) begin
                state_n = rxs ? IDLE : DATA;
                cnt_n   = rxs ? '0 : FULL;
                idx_n   = '0;
            end
            DATA: if (done) begin
                sr_n[idx] = rxs;
                idx_n     = idx + 3'd1;
                cnt_n     = FULL;
                state_n   = idx == 3'd7 ? STOP : DATA;
            end
            STOP: if (done) begin
                state_n = rxs ? IDLE : WAIT_HIGH;
                cnt_n   = '0;
            end
            WAIT_HIGH: if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // sr stays intact until the next frame's data bits, so it doubles as the pending byte
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cmd       <= CMD_NONE;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            hold      <= '0;
            pend      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= bad;
            if (accept && sr != CMD_NONE) begin
                if (cmd != CMD_NONE) begin
                    cmd  <= CMD_NONE;
                    hold <= '0;
                    pend <= 1'b1;
                end else begin
                    cmd       <= sr;
                    cmd_valid <= 1'b1;
                    hold      <= HOLD;
                end
            end else if (pend) begin
                cmd       <= sr;
                cmd_valid <= 1'b1;
                hold      <= HOLD;
                pend      <= 1'b0;
            end else if (hold == HW'(1)) begin
                cmd  <= CMD_NONE;
                hold <= '0;
            end else if (hold != '0) begin
                hold <= hold - HW'(1);
            end
        end
endmodule
